prdecoder_seq: RTL and testbench
================================

# prdecoder_seq

Sequenced 3-to-8 decoder: the receiving end of the priority encoder's 3-bit code. It accepts codes over a valid/ready handshake and buffers them in a 2-entry FIFO. Each code is replayed as a one-hot strobe held for HOLD cycles, followed by GAP idle cycles. A completed-code counter is kept for the bench and for status readout.

## Interface

Parameters:
- HOLD, default 4: cycles each one-hot output is driven; legal range 1..255.
- GAP, default 1: forced all-zero cycles after each strobe; legal range 0..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- code_in  in  3  code to decode.
- valid_in  in  1  code_in is valid.
- ready_out  out  1  block can accept; equals !full, forced 0 while rst=1.
- out  out  8  one-hot decoded strobe; bit code_in set; all zero otherwise.
- out_valid  out  1  high exactly when out is non-zero (state DRIVE).
- busy  out  1  state != IDLE or FIFO non-empty.
- count  out  8  number of strobes completed; wraps 255 -> 0.

## Operation

- Handshake: transfer on a rising edge where valid_in=1 and ready_out=1. The code is written to the FIFO tail.
  - valid_in is ignored when ready_out=0.
  - code_in may change freely when no transfer occurs.
- FIFO: 2 entries, registered fill level 0..2; full = (level==2).
  - A push in the same cycle as a pop is legal when level is 1. Level is unchanged, order is preserved.
  - No push can occur at level 2, even if a pop happens that cycle, because ready_out is computed from the registered level.
- FSM states: IDLE, DRIVE, GAP. Timer is 8 bits.
  - IDLE:
    - FIFO non-empty: pop head, out <= 1<<head, timer <= HOLD-1, go DRIVE.
    - Otherwise stay; out=0.
  - DRIVE: out held constant.
    - timer != 0: decrement timer.
    - timer == 0: count <= count+1 (mod 256) and out <= 0. Then:
      - GAP>0: timer <= GAP-1, go GAP.
      - GAP=0 and FIFO non-empty: pop and load the next strobe directly. This is back-to-back with no zero cycle.
      - Otherwise go IDLE.
  - GAP: out=0.
    - timer != 0: decrement timer.
    - timer == 0 and FIFO non-empty: pop, load strobe, go DRIVE.
    - timer == 0 and FIFO empty: go IDLE.
- Code is not re-sampled during DRIVE. out is always zero or exactly one-hot; it never has two bits set.
- Reset values:
  - state=IDLE, FIFO level=0, timer=0.
  - out=8'h00, out_valid=0, busy=0, count=8'h00.
  - ready_out=0 while rst=1, and 1 in the first cycle after rst drops.
- Reset mid-operation: an in-progress strobe is dropped in the cycle after the reset edge. FIFO contents are discarded and count is not incremented.

## Timing

- Latency: code transferred at edge k, FSM in IDLE with empty FIFO: pop at edge k+1, out one-hot from edge k+1. That is 1 cycle from transfer to strobe (2 edges from valid_in presented).
- Strobe width: exactly HOLD cycles. Zero width between strobes: exactly GAP cycles.
- count increments at the edge that ends DRIVE, i.e. is visible in the same cycle out returns to 0 (or the next strobe starts when GAP=0).
- Sustained throughput: one code per HOLD+GAP cycles.
  - ready_out drops once 2 codes are waiting.
  - ready_out rises in the cycle after the pop that frees a slot.
- All outputs registered except ready_out and busy, which are decoded from registered state only (no combinational path from inputs).

## Test plan

- Reset check: hold rst=1 for 3 cycles with valid_in=1 -> out=00, out_valid=0, busy=0, count=0, ready_out=0. Release -> ready_out=1 next cycle.
- Single code, HOLD=4, GAP=1: send code 3 -> out=8'h08, out_valid=1 for exactly 4 cycles, then 1 zero cycle. count=1, busy falls after GAP.
- Backpressure: hold valid_in=1 with codes 5,6,7,1 -> strobes 8'h20, 8'h40, 8'h80, 8'h02 in order. ready_out=0 whenever 2 entries are queued. No code lost or duplicated.
- Sweep: codes 0..7 in sequence (mirrors the encoder sweep) -> out = 01,02,04,08,10,20,40,80. count=8.
- GAP=0, HOLD=1 build: two queued codes 2,4 -> out 8'h04 then 8'h10 on consecutive cycles, with no zero cycle between them.
- Wrap and reset: 256 strobes -> count returns to 0. Assert rst during the second DRIVE cycle of code 7 -> out=00 and FIFO empty the next cycle, count unchanged from its pre-reset value until the reset edge, then 0.

Source files
------------

// File: rtl/prdecoder_seq.sv
// prdecoder_seq -- sequenced 3-to-8 decoder.
//
// Accepts 3-bit codes over a valid/ready handshake into a 2-entry FIFO and
// replays each one as a one-hot strobe. Each strobe is held for HOLD cycles
// and is followed by GAP forced-zero cycles. Completed strobes are counted
// modulo 256.
//
// Parameters
//   HOLD  cycles each one-hot strobe is driven (1..255)
//   GAP   idle cycles after each strobe (0..255)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   code_in    code to decode
//   valid_in   code_in is valid
//   ready_out  can accept a code (FIFO not full, low during reset)
//   out        registered one-hot strobe, zero otherwise
//   out_valid  registered, high exactly while out is non-zero
//   busy       FSM not idle or FIFO holds codes
//   count      completed strobes, wraps 255 -> 0
module prdecoder_seq #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] count
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam bit         HAS_GAP = (GAP > 0);

  state_t     state_reg;
  logic [7:0] timer_reg;
  logic [7:0] out_reg;
  logic       out_valid_reg;
  logic [7:0] count_reg;

  logic [1:0] level_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [2:0] fifo_mem [2];

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       timer_zero;
  logic [2:0] head;
  logic [7:0] head_onehot;

  assign full       = (level_reg == 2'd2);
  assign empty      = (level_reg == 2'd0);
  assign timer_zero = (timer_reg == 8'd0);

  // ready_out depends only on the registered level (and reset), so a pop in
  // the same cycle never lets a third code in.
  assign ready_out = !rst && !full;
  assign push      = valid_in && ready_out;
  assign head      = fifo_mem[rd_ptr_reg];

  // The FSM pops whenever it is about to load a new strobe.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      unique case (state_reg)
        ST_IDLE:  pop = 1'b1;
        ST_DRIVE: pop = timer_zero && !HAS_GAP;
        ST_GAP:   pop = timer_zero;
        default:  pop = 1'b0;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign head_onehot[gi] = (head == 3'(gi));
    end
  endgenerate

  // FIFO storage needs no reset: an entry is only read while level says it
  // was written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= code_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      unique case ({push, pop})
        2'b10:   level_reg <= level_reg + 2'd1;
        2'b01:   level_reg <= level_reg - 2'd1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= 8'd0;
      out_reg       <= 8'h00;
      out_valid_reg <= 1'b0;
      count_reg     <= 8'h00;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            out_reg       <= head_onehot;
            out_valid_reg <= 1'b1;
            timer_reg     <= HOLD_M1;
            state_reg     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (!timer_zero) begin
            timer_reg <= timer_reg - 8'd1;
          end else begin
            count_reg <= count_reg + 8'd1;
            if (pop) begin
              // GAP=0: next strobe starts with no zero cycle in between.
              out_reg       <= head_onehot;
              out_valid_reg <= 1'b1;
              timer_reg     <= HOLD_M1;
            end else if (HAS_GAP) begin
              out_reg       <= 8'h00;
              out_valid_reg <= 1'b0;
              timer_reg     <= GAP_M1;
              state_reg     <= ST_GAP;
            end else begin
              out_reg       <= 8'h00;
              out_valid_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (!timer_zero) begin
            timer_reg <= timer_reg - 8'd1;
          end else if (pop) begin
            out_reg       <= head_onehot;
            out_valid_reg <= 1'b1;
            timer_reg     <= HOLD_M1;
            state_reg     <= ST_DRIVE;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;
  assign busy      = (state_reg != ST_IDLE) || !empty;

endmodule

// File: tb/tb_prdecoder_seq.sv
// Testbench for prdecoder_seq. A scoreboard queue holds the expected strobes
// pushed at each accepted transfer; a monitor checks every completed strobe
// (value, width, gap, count). A second instance built with HOLD=1, GAP=0
// checks back-to-back strobes.
module tb_prdecoder_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code_in = 3'd0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic [7:0] count;

  logic [2:0] code0_in = 3'd0;
  logic       valid0_in = 1'b0;
  logic       ready0_out;
  logic [7:0] out0;
  logic       out0_valid;
  logic       busy0;
  logic [7:0] count0;

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  prdecoder_seq #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in),
    .ready_out(ready_out), .out(out), .out_valid(out_valid),
    .busy(busy), .count(count)
  );

  prdecoder_seq #(.HOLD(1), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .code_in(code0_in), .valid_in(valid0_in),
    .ready_out(ready0_out), .out(out0), .out_valid(out0_valid),
    .busy(busy0), .count(count0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic [7:0] prev_out = 8'h00;
  logic [7:0] exp_count = 8'h00;
  int run_len = 0;
  int zero_len = 0;
  bit had_strobe = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_count = 8'h00;
        prev_out = 8'h00;
        run_len = 0;
        zero_len = 0;
        had_strobe = 0;
      end else begin
        checks++;
        if (out_valid !== (out != 8'h00) || !$onehot0(out) || (out != 8'h00 && !busy)) begin
          failures++;
          $display("FAIL mon_flags: out=%0h out_valid=%0b busy=%0b", out, out_valid, busy);
        end
        if (out != prev_out) begin
          if (prev_out != 8'h00) begin
            exp_count = exp_count + 8'd1;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL mon_unexpected: got strobe %0h expected none", prev_out);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              checks++;
              if (prev_out !== e || run_len != HOLD || count !== exp_count) begin
                failures++;
                $display("FAIL mon_strobe: got out=%0h width=%0d count=%0d expected out=%0h width=%0d count=%0d",
                         prev_out, run_len, count, e, HOLD, exp_count);
              end else begin
                $display("ok   strobe %02h width=%0d count=%0d", prev_out, run_len, count);
              end
            end
          end
          if (out != 8'h00) begin
            if (had_strobe) begin
              int g;
              g = (prev_out == 8'h00) ? zero_len : 0;
              checks++;
              if (g < GAP) begin
                failures++;
                $display("FAIL mon_gap: got %0d zero cycles expected >= %0d", g, GAP);
              end
            end
            had_strobe = 1;
            run_len = 1;
          end else begin
            zero_len = 1;
          end
        end else if (out != 8'h00) begin
          run_len++;
        end else begin
          zero_len++;
        end
        prev_out = out;
      end
    end
  end

  // Present a code at a falling edge; returns at the falling edge after the
  // transfer edge with valid_in low.
  task automatic send(input logic [2:0] c);
    int t;
    logic [7:0] oh;
    oh = 8'h01;
    code_in = c;
    valid_in = 1'b1;
    t = 0;
    while (!ready_out && t < 200) begin
      @(negedge clk);
      t++;
    end
    stalls += t;
    if (!ready_out) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready_out=%0b expected 1", ready_out);
    end else begin
      exp_q.push_back(oh << c);
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with valid_in asserted: nothing must be accepted.
    valid_in = 1'b1;
    code_in = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h0);
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_release_ready", 32'(ready_out), 32'h1);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Single code: latency, width, gap, busy fall.
    send(3'd3);
    chk("single_latency_zero", 32'(out), 32'h00);
    @(negedge clk);
    chk("single_out", 32'(out), 32'h08);
    chk("single_out_valid", 32'(out_valid), 32'h1);
    repeat (4) @(negedge clk);
    chk("single_gap_out", 32'(out), 32'h00);
    chk("single_gap_busy", 32'(busy), 32'h1);
    chk("single_count", 32'(count), 32'h1);
    @(negedge clk);
    chk("single_busy_fall", 32'(busy), 32'h0);

    // Backpressure: four codes with valid held.
    stalls = 0;
    send(3'd5);
    send(3'd6);
    send(3'd7);
    send(3'd1);
    chk("bp_stalled", 32'(stalls > 0), 32'h1);
    wait_idle();
    chk("bp_count", 32'(count), 32'd5);

    // Sweep of all codes.
    for (int i = 0; i < 8; i++) send(3'(i));
    wait_idle();
    chk("sweep_count", 32'(count), 32'd13);
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    // Wrap: 256 strobes in total since reset.
    for (int i = 0; i < 243; i++) send(3'(i));
    wait_idle();
    chk("wrap_count", 32'(count), 32'h00);

    // Reset during the second DRIVE cycle of code 7, with code 1 queued.
    send(3'd5);
    send(3'd6);
    wait_idle();
    chk("pre_rst_count", 32'(count), 32'd2);
    send(3'd7);
    send(3'd1);
    @(negedge clk);
    chk("rst_mid_out", 32'(out), 32'h80);
    chk("rst_mid_count", 32'(count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_after", 32'(out), 32'h00);
    chk("rst_mid_busy_after", 32'(busy), 32'h0);
    chk("rst_mid_count_after", 32'(count), 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_replay", 32'(out), 32'h00);
    chk("rst_mid_idle", 32'(busy), 32'h0);

    // HOLD=1, GAP=0 instance: codes 2 then 4 back-to-back.
    code0_in = 3'd2;
    valid0_in = 1'b1;
    @(negedge clk);
    code0_in = 3'd4;
    @(negedge clk);
    valid0_in = 1'b0;
    chk("b2b_first", 32'(out0), 32'h04);
    @(negedge clk);
    chk("b2b_second", 32'(out0), 32'h10);
    chk("b2b_count1", 32'(count0), 32'd1);
    chk("b2b_valid", 32'(out0_valid), 32'h1);
    @(negedge clk);
    chk("b2b_end", 32'(out0), 32'h00);
    chk("b2b_count2", 32'(count0), 32'd2);
    chk("b2b_busy", 32'(busy0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
